// File: rtl/cpu_step_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_pkg
// Brief    : Shared state encodings and default timing constants for the
//            MiniRISC execution sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_step_pkg;

    localparam int STATE_W = 2;

    // Encoding is visible on the board LEDs, so the values are fixed.
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_STEP  = 2'd2;
    localparam logic [STATE_W-1:0] ST_BREAK = 2'd3;

    localparam int DEFAULT_RUN_DIV    = 50_000_000;
    localparam int DEFAULT_DEB_CYCLES = 1_000_000;

    function automatic logic is_halted_state(input logic [STATE_W-1:0] s);
        return (s == ST_IDLE) || (s == ST_BREAK);
    endfunction

endpackage : cpu_step_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : 2-FF synchronizer, optional debounce (STEP_DEBOUNCE_EN) and
//            rising-edge detector producing a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer
    import cpu_step_pkg::*;
#(
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse_out
);

    logic r_sync_meta;
    logic r_sync;
    logic r_level_d;
    logic w_level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= btn_in;
            r_sync      <= r_sync_meta;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;

    // The level only follows the synchronized input after it has differed
    // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync == r_level) begin
            r_cnt   <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_level <= r_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_level;
`else
    logic w_unused_deb;
    assign w_unused_deb = ^DEB_CYCLES;
    assign w_level      = r_sync;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign pulse_out = w_level & ~r_level_d;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_step_controller
// Brief    : Issues single-cycle clock enables to the MiniRISC core in halted,
//            free-run, single-step and PC-breakpoint modes. Step-button
//            debounce is built only when STEP_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_step_controller
    import cpu_step_pkg::*;
#(
    parameter int RUN_DIV    = DEFAULT_RUN_DIV,
    parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES,
    parameter int PC_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_sw,
    input  logic               step_btn,
    input  logic               halt_req,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_ce,
    output logic               halted,
    output logic [STATE_W-1:0] state,
    output logic [31:0]        step_count
);

    localparam int c_div_w = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RUN_DIV - 1);

    logic [STATE_W-1:0] r_state;
    logic [c_div_w-1:0] r_div;
    logic               r_cpu_ce;
    logic               r_halted;
    logic [31:0]        r_step_count;

    logic [STATE_W-1:0] w_state_nxt;
    logic [c_div_w-1:0] w_div_nxt;
    logic               w_ce_nxt;
    logic [31:0]        w_count_nxt;
    logic               w_step_pulse;
    logic               w_bp_hit;

    button_debouncer #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (step_btn),
        .pulse_out (w_step_pulse)
    );

    // PC is the next instruction to execute, so a hit suppresses its pulse.
    assign w_bp_hit = bp_en && (pc == bp_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_ce_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!halt_req && run_sw) begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = '0;
                end else if (w_step_pulse) begin
                    w_state_nxt = ST_STEP;
                    w_ce_nxt    = 1'b1;
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (halt_req || !run_sw) begin
                    w_state_nxt = ST_IDLE;
                    w_div_nxt   = '0;
                end else if (r_div == c_div_last) begin
                    w_div_nxt = '0;
                    if (w_bp_hit) begin
                        w_state_nxt = ST_BREAK;
                    end else begin
                        w_ce_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            ST_BREAK: begin
                // Stepping here executes the breakpoint instruction itself.
                if (w_step_pulse) begin
                    w_state_nxt = ST_STEP;
                    w_ce_nxt    = 1'b1;
                end else if (!run_sw) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_div_nxt   = '0;
            end
        endcase
        w_count_nxt = w_ce_nxt ? (r_step_count + 32'd1) : r_step_count;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_cpu_ce     <= 1'b0;
            r_halted     <= 1'b1;
            r_step_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_div        <= w_div_nxt;
            r_cpu_ce     <= w_ce_nxt;
            r_halted     <= is_halted_state(w_state_nxt);
            r_step_count <= w_count_nxt;
        end
    end

    assign cpu_ce     = r_cpu_ce;
    assign halted     = r_halted;
    assign state      = r_state;
    assign step_count = r_step_count;

endmodule : cpu_step_controller
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_step_controller
// Brief    : Scoreboard bench: stimulus pushes expected cpu_ce pulses (cycle
//            window and step_count), an independent monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_step_controller;

    localparam int RUN_DIV    = 4;
    localparam int DEB_CYCLES = 3;
    localparam int PC_W       = 32;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_BREAK = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run_sw = 1'b0;
    logic            step_btn = 1'b0;
    logic            halt_req = 1'b0;
    logic            bp_en = 1'b0;
    logic [PC_W-1:0] bp_addr = '0;
    logic [PC_W-1:0] pc;
    logic            cpu_ce;
    logic            halted;
    logic [1:0]      state;
    logic [31:0]     step_count;

    cpu_step_controller #(
        .RUN_DIV    (RUN_DIV),
        .DEB_CYCLES (DEB_CYCLES),
        .PC_W       (PC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_ce     (cpu_ce),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: one instruction retires per enable.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (cpu_ce) pc <= pc + 4;
    end

    typedef struct {
        int          lo;
        int          hi;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_count = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int lo, input int hi);
        exp_t e;
        m_count = m_count + 32'd1;
        e.lo  = lo;
        e.hi  = hi;
        e.cnt = m_count;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_ce === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse cycle=%0d step_count=%0d required=no pulse", cyc, step_count);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc < mon_e.lo || cyc > mon_e.hi) begin
                    failures++;
                    $display("FAIL pulse_cycle actual=%0d required=%0d..%0d", cyc, mon_e.lo, mon_e.hi);
                end
                check("pulse_count", step_count, mon_e.cnt);
            end
        end
    end

    // Free-run for n edges after asserting run_sw; pulses land every RUN_DIV
    // edges counted from the edge that enters RUN.
    task automatic do_run(input int n);
        int e0;
        @(posedge clk); #2;
        e0 = cyc;
        halt_req = 1'b0;
        rst_n    = 1'b1;
        run_sw   = 1'b1;
        for (int k = 1; RUN_DIV * k <= n - 1; k++)
            push_exp(e0 + 1 + RUN_DIV * k, e0 + 1 + RUN_DIV * k);
        @(posedge clk); @(negedge clk);
        check("run_entry_state", state, S_RUN);
        check("run_entry_halted", halted, 0);
        repeat (n - 1) @(posedge clk);
        #2 run_sw = 1'b0;
        @(posedge clk); @(negedge clk);
        check("run_exit_state", state, S_IDLE);
        check("run_exit_halted", halted, 1);
        repeat (RUN_DIV * 2) @(negedge clk);
        check("run_drained", sb.size(), 0);
        check("run_count", step_count, m_count);
    endtask

    // One press; the enable must appear within synchronizer+debounce latency.
    task automatic press_step(input int hold);
        int e0;
        @(posedge clk); #2;
        e0 = cyc;
        push_exp(e0 + 3, e0 + 3 + DEB_CYCLES + 2);
        step_btn = 1'b1;
        repeat (hold) @(posedge clk);
        #2 step_btn = 1'b0;
        repeat (DEB_CYCLES + 8) @(negedge clk);
        check("step_end_state", state, S_IDLE);
        check("step_end_halted", halted, 1);
        check("step_drained", sb.size(), 0);
        check("step_count", step_count, m_count);
    endtask

    task automatic bp_test(input logic [PC_W-1:0] addr, input bit use_step);
        int              e0;
        int              t;
        logic [PC_W-1:0] mpc;
        @(posedge clk); #2;
        rst_n = 1'b0; run_sw = 1'b0; halt_req = 1'b0;
        m_count = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bp_en   = 1'b1;
        bp_addr = addr;
        @(posedge clk); #2;
        e0 = cyc;
        run_sw = 1'b1;
        t   = e0 + 1 + RUN_DIV;
        mpc = '0;
        while (mpc != addr) begin
            push_exp(t, t);
            mpc = mpc + 4;
            t   = t + RUN_DIV;
        end
        repeat (t - e0) @(posedge clk);
        @(negedge clk);
        check("bp_state", state, S_BREAK);
        check("bp_halted", halted, 1);
        check("bp_pc", pc, addr);
        repeat (5) @(negedge clk);
        check("bp_hold_state", state, S_BREAK);
        if (use_step) begin
            @(posedge clk); #2 halt_req = 1'b1;
            press_step(DEB_CYCLES + 2);
            check("bp_step_pc", pc, addr + 4);
        end else begin
            @(posedge clk); #2 run_sw = 1'b0;
            @(posedge clk); @(negedge clk);
            check("bp_exit_state", state, S_IDLE);
        end
        @(posedge clk); #2;
        run_sw = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  e0;
        bit  found;
        rst_n  = 1'b0;
        run_sw = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_state", state, S_IDLE);
        check("rst_halted", halted, 1);
        check("rst_step_count", step_count, 0);

        do_run(21);
        check("run_five_pulses", step_count, 5);

        press_step(6);
`ifdef STEP_DEBOUNCE_EN
        @(posedge clk); #2;
        for (int i = 0; i < 12; i++) begin
            step_btn = ~step_btn;
            @(posedge clk); #2;
        end
        step_btn = 1'b0;
        repeat (DEB_CYCLES + 8) @(negedge clk);
        check("bounce_count", step_count, m_count);
        check("bounce_state", state, S_IDLE);
`endif
        for (int i = 0; i < 3; i++) press_step($urandom_range(DEB_CYCLES + 1, 8));

        // Halt while divider is 2, then rerun to expose a stale divider.
        @(posedge clk); #2;
        run_sw = 1'b1;
        repeat (3) @(posedge clk);
        #2 halt_req = 1'b1;
        @(posedge clk); @(negedge clk);
        check("halt_state", state, S_IDLE);
        check("halt_count", step_count, m_count);
        do_run($urandom_range(6, 30));

        for (int i = 0; i < 3; i++) do_run($urandom_range(2, 30));

        bp_test(32'h8, 1'b1);
        bp_test(32'(4 * $urandom_range(1, 4)), 1'b0);

        // Asynchronous reset while the step enable is high.
        @(posedge clk); #2;
        e0 = cyc;
        push_exp(e0 + 3, e0 + 3 + DEB_CYCLES + 2);
        step_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (cpu_ce === 1'b1) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL step_timeout actual=no pulse required=pulse");
        end else begin
            #2 rst_n = 1'b0;
            #1;
            check("arst_cpu_ce", cpu_ce, 0);
            check("arst_step_count", step_count, 0);
            check("arst_state", state, S_IDLE);
            check("arst_halted", halted, 1);
        end
        m_count  = '0;
        sb.delete();
        step_btn = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_arst_state", state, S_IDLE);
        check("post_arst_count", step_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cpu_step_controller
`default_nettype wire
